// File: rtl/gate_finder_pkg.sv
// Shared types and slot/vector helpers for the 74xx gate test sequencer.
// Pin masks are built by shifting so callers never index the pin bus with a computed value.
package gate_finder_pkg;

    localparam int unsigned NPINS     = 12;
    localparam int unsigned MAX_SLOTS = 6;

    typedef enum logic [2:0] {
        GT_NONE = 3'd0,
        GT_NOT  = 3'd1,
        GT_AND  = 3'd2,
        GT_OR   = 3'd3,
        GT_XOR  = 3'd4
    } gate_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_GATE_END,
        ST_DONE
    } state_t;

    function automatic logic is_valid_type(logic [2:0] t);
        return (t >= 3'd1) && (t <= 3'd4);
    endfunction

    function automatic logic [2:0] slot_count(gate_t t);
        case (t)
            GT_NOT:                return 3'd6;
            GT_AND, GT_OR, GT_XOR: return 3'd4;
            default:               return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] vec_count(gate_t t);
        case (t)
            GT_NOT:                return 3'd2;
            GT_AND, GT_OR, GT_XOR: return 3'd4;
            default:               return 3'd0;
        endcase
    endfunction

    function automatic logic [NPINS-1:0] pin_bit(int unsigned idx);
        return {{(NPINS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // NOT slots sit on pin pairs (A=2g, Y=2g+1); 2-input slots on triples (A=3g, B=3g+1, Y=3g+2).
    function automatic logic [NPINS-1:0] input_mask(gate_t t, logic [2:0] g);
        int unsigned gi;
        gi = 32'(g);
        if (t == GT_NOT)
            return pin_bit(2 * gi);
        return pin_bit(3 * gi) | pin_bit(3 * gi + 1);
    endfunction

    function automatic logic [NPINS-1:0] output_mask(gate_t t, logic [2:0] g);
        int unsigned gi;
        gi = 32'(g);
        if (t == GT_NOT)
            return pin_bit(2 * gi + 1);
        return pin_bit(3 * gi + 2);
    endfunction

    function automatic logic [NPINS-1:0] vector_bits(gate_t t, logic [2:0] g, logic [1:0] v);
        logic [NPINS-1:0] bits;
        int unsigned      gi;
        gi   = 32'(g);
        bits = '0;
        if (t == GT_NOT) begin
            if (v[0]) bits = pin_bit(2 * gi);
        end else begin
            if (v[0]) bits = bits | pin_bit(3 * gi);
            if (v[1]) bits = bits | pin_bit(3 * gi + 1);
        end
        return bits;
    endfunction

    function automatic logic expected_y(gate_t t, logic [1:0] v);
        case (t)
            GT_NOT:  return ~v[0];
            GT_AND:  return v[0] & v[1];
            GT_OR:   return v[0] | v[1];
            GT_XOR:  return v[0] ^ v[1];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Request/result and probe-pin bundle between the gate finder, the sequencer and the GPIO pads.
interface gate_test_sequencer_if;
    import gate_finder_pkg::*;

    logic             start;
    logic             abort;
    logic [2:0]       gate_type;
    logic [NPINS-1:0] pin_in;
    logic [NPINS-1:0] pin_out;
    logic [NPINS-1:0] pin_dir;
    logic             busy;
    logic             done;
    logic             error;
    logic [5:0]       gate_pass;
    logic [2:0]       pass_cnt;
    logic             chip_ok;

    modport master (
        output start, abort, gate_type, pin_in,
        input  pin_out, pin_dir, busy, done, error, gate_pass, pass_cnt, chip_ok
    );

    modport slave (
        input  start, abort, gate_type, pin_in,
        output pin_out, pin_dir, busy, done, error, gate_pass, pass_cnt, chip_ok
    );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter that times the settle window between driving a vector and sampling Y.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= W'(SETTLE_CYCLES - 1);
        else if (dec && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks every input vector over every slot of the requested gate type and grades each slot.
// All outputs, including the pin drive, are registered so the pads see glitch-free levels.
module gate_test_sequencer
    import gate_finder_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 50
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    gate_test_sequencer_if.slave bus
);

    state_t     state;
    gate_t      gtype;
    logic [2:0] g;
    logic [1:0] v;
    logic       vec_ok;
    logic       timer_zero;
    logic [1:0] last_v;
    logic [2:0] last_g;
    logic       y_level;
    gate_t      req_type;

    always_comb begin
        req_type = gate_t'(bus.gate_type);
        last_v   = 2'(vec_count(gtype) - 3'd1);
        last_g   = slot_count(gtype) - 3'd1;
        y_level  = |(bus.pin_in & output_mask(gtype, g));
    end

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (CLOCK_50),
        .reset(reset),
        .load (state == ST_DRIVE),
        .dec  (state == ST_SETTLE),
        .zero (timer_zero)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            gtype         <= GT_NONE;
            g             <= '0;
            v             <= '0;
            vec_ok        <= 1'b0;
            bus.pin_out   <= '0;
            bus.pin_dir   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            bus.gate_pass <= '0;
            bus.pass_cnt  <= '0;
            bus.chip_ok   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if ((state != ST_IDLE) && bus.abort) begin
                state         <= ST_IDLE;
                bus.pin_out   <= '0;
                bus.pin_dir   <= '0;
                bus.busy      <= 1'b0;
                bus.gate_pass <= '0;
                bus.pass_cnt  <= '0;
                bus.chip_ok   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            bus.gate_pass <= '0;
                            bus.pass_cnt  <= '0;
                            bus.chip_ok   <= 1'b0;
                            bus.busy      <= 1'b1;
                            g             <= '0;
                            v             <= '0;
                            if (is_valid_type(bus.gate_type)) begin
                                gtype       <= req_type;
                                bus.error   <= 1'b0;
                                bus.pin_dir <= input_mask(req_type, 3'd0);
                                bus.pin_out <= vector_bits(req_type, 3'd0, 2'd0);
                                state       <= ST_DRIVE;
                            end else begin
                                gtype     <= GT_NONE;
                                bus.error <= 1'b1;
                                state     <= ST_DONE;
                            end
                        end
                    end

                    ST_DRIVE: begin
                        if (v == 2'd0) vec_ok <= 1'b1;
                        state <= ST_SETTLE;
                    end

                    ST_SETTLE: begin
                        if (timer_zero) state <= ST_SAMPLE;
                    end

                    ST_SAMPLE: begin
                        if (y_level != expected_y(gtype, v)) vec_ok <= 1'b0;
                        if (v == last_v) begin
                            bus.pin_dir <= '0;
                            bus.pin_out <= '0;
                            state       <= ST_GATE_END;
                        end else begin
                            v           <= v + 2'd1;
                            bus.pin_dir <= input_mask(gtype, g);
                            bus.pin_out <= vector_bits(gtype, g, v + 2'd1);
                            state       <= ST_DRIVE;
                        end
                    end

                    ST_GATE_END: begin
                        bus.gate_pass[g] <= vec_ok;
                        bus.pass_cnt     <= bus.pass_cnt + {2'b00, vec_ok};
                        if (g == last_g) begin
                            state <= ST_DONE;
                        end else begin
                            g           <= g + 3'd1;
                            v           <= '0;
                            bus.pin_dir <= input_mask(gtype, g + 3'd1);
                            bus.pin_out <= vector_bits(gtype, g + 3'd1, 2'd0);
                            state       <= ST_DRIVE;
                        end
                    end

                    ST_DONE: begin
                        // An invalid request has zero slots, so guard against 0 == 0 reading as a pass.
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        bus.chip_ok <= !bus.error && (bus.pass_cnt == slot_count(gtype));
                        bus.pin_dir <= '0;
                        bus.pin_out <= '0;
                        state       <= ST_IDLE;
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomised and directed bench: a behavioural 74xx chip model answers on the pins and a
// slot-by-slot reference predicts the grading, latency and pin-drive legality.
module tb_gate_test_sequencer;
    import gate_finder_pkg::*;

    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst;

    gate_test_sequencer_if bus ();

    gate_test_sequencer #(
        .SETTLE_CYCLES(S)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         chip_kind;
    logic [5:0] stuck;
    int         mon_type = 0;
    int         viol     = 0;
    bit         legal;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [11:0] bitmask(int i);
        logic [11:0] m;
        m = 12'd1 << i;
        return m;
    endfunction

    function automatic bit getbit(logic [11:0] vec, int i);
        return |(vec & bitmask(i));
    endfunction

    function automatic int nslots(int t);
        if (t == 1) return 6;
        if (t >= 2 && t <= 4) return 4;
        return 0;
    endfunction

    function automatic int pin_a(int t, int g); return (t == 1) ? 2 * g : 3 * g; endfunction
    function automatic int pin_b(int g);        return 3 * g + 1;                endfunction
    function automatic int pin_y(int t, int g); return (t == 1) ? 2 * g + 1 : 3 * g + 2; endfunction

    function automatic bit truth(int t, bit a, bit b);
        case (t)
            1:       return !a;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [11:0] in_mask_tb(int t, int g);
        return (t == 1) ? bitmask(pin_a(t, g)) : (bitmask(pin_a(t, g)) | bitmask(pin_b(g)));
    endfunction

    // Chip kind uses the gate numbering: 1=7404, 2=7408, 3=7432, 4=7486. Undriven pins read low.
    function automatic logic [11:0] chip_response(logic [11:0] dir, logic [11:0] out, int kind,
                                                  logic [5:0] stk);
        logic [11:0] lvl;
        bit          a, b, y;
        lvl = dir & out;
        for (int g = 0; g < nslots(kind); g++) begin
            a = getbit(lvl, pin_a(kind, g));
            b = 1'b0;
            if (kind != 1) b = getbit(lvl, pin_b(g));
            y = truth(kind, a, b) && !stk[g];
            if (!getbit(dir, pin_y(kind, g))) begin
                if (y) lvl = lvl | bitmask(pin_y(kind, g));
                else   lvl = lvl & ~bitmask(pin_y(kind, g));
            end
        end
        return lvl;
    endfunction

    assign bus.pin_in = chip_response(bus.pin_dir, bus.pin_out, chip_kind, stuck);

    function automatic void predict(input int t, input int chip, input logic [5:0] stk,
                                    output logic [5:0] gp, output int pc, output bit ok,
                                    output bit err, output int lat);
        logic [11:0] out, lvl;
        int          nv;
        bit          pass;
        gp  = '0;
        pc  = 0;
        err = (nslots(t) == 0);
        nv  = (t == 1) ? 2 : 4;
        for (int g = 0; g < nslots(t); g++) begin
            pass = 1'b1;
            for (int v = 0; v < nv; v++) begin
                out = '0;
                if (v % 2 == 1)            out = out | bitmask(pin_a(t, g));
                if (t != 1 && v / 2 == 1)  out = out | bitmask(pin_b(g));
                lvl = chip_response(in_mask_tb(t, g), out, chip, stk);
                if (getbit(lvl, pin_y(t, g)) != truth(t, v % 2 == 1, v / 2 == 1)) pass = 1'b0;
            end
            gp[g] = pass;
            pc += int'(pass);
        end
        ok  = !err && (pc == nslots(t));
        // Counted in edges after the one that samples start.
        lat = nslots(t) * (nv * (int'(S) + 2) + 1) + 1;
    endfunction

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if ((bus.pin_out & ~bus.pin_dir) != '0) viol++;
            if (bus.pin_dir != '0) begin
                legal = 1'b0;
                for (int g = 0; g < nslots(mon_type); g++)
                    if (bus.pin_dir == in_mask_tb(mon_type, g)) legal = 1'b1;
                if (!legal) viol++;
            end
        end
    end

    task automatic run_test(input string name, input int t, input int chip, input logic [5:0] stk,
                            input bit poke);
        logic [5:0] gp;
        int         pc, lat_exp, lat, viol0;
        bit         ok, err;
        predict(t, chip, stk, gp, pc, ok, err, lat_exp);
        chip_kind = chip;
        stuck     = stk;
        mon_type  = t;
        viol0     = viol;
        @(negedge clk);
        bus.gate_type = 3'(t);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (!err) check({name, ".busy"}, bus.busy, 1);
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 20) begin
                bus.start     = 1'b1;
                bus.gate_type = 3'($urandom_range(0, 7));
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
        end
        bus.start = 1'b0;
        check({name, ".lat"}, lat, lat_exp);
        check({name, ".gate_pass"}, bus.gate_pass, gp);
        check({name, ".pass_cnt"}, bus.pass_cnt, pc);
        check({name, ".chip_ok"}, bus.chip_ok, ok);
        check({name, ".error"}, bus.error, err);
        check({name, ".busy_end"}, bus.busy, 0);
        @(negedge clk);
        check({name, ".done_pulse"}, bus.done, 0);
        check({name, ".hold"}, bus.gate_pass, gp);
        check({name, ".pin_legal"}, viol - viol0, 0);
    endtask

    initial begin
        int         lat, dones, t, chip;
        logic [5:0] stk;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.gate_type = '0;
        chip_kind     = 2;
        stuck         = '0;
        repeat (2) @(negedge clk);
        check("reset.outs", {bus.pin_dir, bus.pin_out, bus.busy, bus.done, bus.error,
                             bus.gate_pass, bus.pass_cnt, bus.chip_ok}, 0);
        rst = 1'b0;

        run_test("and_ideal", 2, 2, 6'b000000, 1'b1);
        run_test("not_stuck3", 1, 1, 6'b001000, 1'b1);
        run_test("xor_on_or", 4, 3, 6'b000000, 1'b0);
        run_test("type0", 0, 2, 6'b000000, 1'b0);
        run_test("type5", 5, 2, 6'b000000, 1'b0);

        // start together with abort while idle must not launch a test
        @(negedge clk);
        bus.gate_type = 3'd2;
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort.busy", bus.busy, 0);
        check("start_abort.pin_dir", bus.pin_dir, 0);

        // abort during SETTLE of slot 2, with a stray start earlier in the run
        chip_kind = 2;
        stuck     = '0;
        mon_type  = 2;
        @(negedge clk);
        bus.gate_type = 3'd2;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones     = 0;
        for (lat = 1; lat <= 51; lat++) begin
            @(negedge clk);
            bus.start = (lat == 5);
            if (lat == 5) bus.gate_type = 3'd1;
            if (bus.done) dones++;
        end
        check("abort.slot2_pins", bus.pin_dir, in_mask_tb(2, 2));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort.pin_dir", bus.pin_dir, 0);
        check("abort.busy", bus.busy, 0);
        check("abort.results", {bus.gate_pass, bus.pass_cnt, bus.chip_ok}, 0);
        repeat (150) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort.no_done", dones, 0);
        run_test("after_abort", 2, 2, 6'b000000, 1'b0);

        // asynchronous reset in the first SAMPLE of a NOT run
        chip_kind = 1;
        mon_type  = 1;
        @(negedge clk);
        bus.gate_type = 3'd1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst.pre_pins", bus.pin_dir, in_mask_tb(1, 0));
        #1 rst = 1'b1;
        #1 check("rst.async_outs", {bus.pin_dir, bus.pin_out, bus.busy, bus.done, bus.error,
                                    bus.gate_pass, bus.pass_cnt, bus.chip_ok}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_test("after_rst", 1, 1, 6'b000000, 1'b0);

        for (int i = 0; i < 12; i++) begin
            t    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
            chip = $urandom_range(1, 4);
            stk  = $urandom_range(0, 1) ? 6'($urandom_range(0, 63)) : 6'd0;
            run_test($sformatf("rand%0d", i), t, chip, stk, nslots(t) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
